// File: rtl/wall_pkg.sv
// Shared constants, state encoding and helpers for the wall datapath, height generator
// and renderer.
package wall_pkg;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned WALL_WIDTH  = 4;
  localparam int unsigned HOLE_HEIGHT = 50;

  localparam logic [2:0] WALL_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int unsigned CW   = 3;
  localparam int unsigned ColW = $clog2(WALL_WIDTH);

  localparam logic [YW-1:0] HOLE_Y_MAX = YW'(SCREEN_H - HOLE_HEIGHT);

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw,
    StFinish
  } wall_state_e;

  // Keeps the whole hole on screen.
  function automatic logic [YW-1:0] clamp_hole(input logic [YW-1:0] hy);
    return (hy > HOLE_Y_MAX) ? HOLE_Y_MAX : hy;
  endfunction

endpackage

// File: rtl/wall_renderer_if.sv
// Frame request and pixel-output bundle between a frame controller and the wall renderer.
interface wall_renderer_if;

  logic                       start;
  logic [wall_pkg::XW-1:0]    wall_x;
  logic [wall_pkg::YW-1:0]    hole_y;
  logic [wall_pkg::XW-1:0]    x;
  logic [wall_pkg::YW-1:0]    y;
  logic [wall_pkg::CW-1:0]    colour;
  logic                       plot;
  logic                       busy;
  logic                       done;

  modport master (
    output start, wall_x, hole_y,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, wall_x, hole_y,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/pixel_scan_counter.sv
// Row-major scan over a WALL_WIDTH x SCREEN_H strip; column is the inner loop and the
// counter wraps to the origin after the last pixel.
module pixel_scan_counter
  import wall_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            en_i,
  output logic [ColW-1:0] col_o,
  output logic [YW-1:0]   row_o,
  output logic            last_o
);

  logic [ColW-1:0] col_q, col_d;
  logic [YW-1:0]   row_q, row_d;
  logic            col_last, row_last;

  assign col_last = (col_q == ColW'(WALL_WIDTH - 1));
  assign row_last = (row_q == YW'(SCREEN_H - 1));
  assign last_o   = col_last && row_last;
  assign col_o    = col_q;
  assign row_o    = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/wall_renderer.sv
// Renders one frame of the wall: erases the previous wall strip, then draws the new one
// with its hole, emitting one registered pixel per cycle to the VGA adapter.
module wall_renderer
  import wall_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  wall_renderer_if.slave bus
);

  wall_state_e     state_q;
  logic [XW-1:0]   cur_x_q, prev_x_q;
  logic [YW-1:0]   cur_hole_q;
  logic            prev_valid_q;
  logic            handoff_q;

  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   colour_q;
  logic            plot_q, busy_q, done_q;

  logic [ColW-1:0] col;
  logic [YW-1:0]   row;
  logic            last;

  logic            scanning;
  logic            scan_clear;
  logic [XW-1:0]   base_x;
  logic [XW:0]     sum;
  logic            in_hole;
  logic            pix_plot;
  logic [CW-1:0]   pix_colour;

  pixel_scan_counter u_scan (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clear_i (scan_clear),
    .en_i    (scanning),
    .col_o   (col),
    .row_o   (row),
    .last_o  (last)
  );

  // The handoff cycle after ERASE emits nothing and restarts the scan for DRAW.
  always_comb begin
    scanning   = ((state_q == StErase) && !handoff_q) || (state_q == StDraw);
    scan_clear = (state_q == StIdle) || (state_q == StFinish) || handoff_q;
    base_x     = (state_q == StErase) ? prev_x_q : cur_x_q;
    sum        = {1'b0, base_x} + {{(XW + 1 - ColW){1'b0}}, col};
    in_hole    = (state_q == StDraw) && (row >= cur_hole_q) &&
                 (row < cur_hole_q + YW'(HOLE_HEIGHT));
    pix_plot   = scanning && (sum < (XW + 1)'(SCREEN_W)) && !in_hole;
    pix_colour = (state_q == StErase) ? BG_COLOUR : WALL_COLOUR;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cur_x_q      <= '0;
      prev_x_q     <= '0;
      cur_hole_q   <= '0;
      prev_valid_q <= 1'b0;
      handoff_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      plot_q <= pix_plot;
      if (scanning) begin
        x_q      <= sum[XW-1:0];
        y_q      <= row;
        colour_q <= pix_colour;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            cur_x_q    <= bus.wall_x;
            cur_hole_q <= clamp_hole(bus.hole_y);
            busy_q     <= 1'b1;
            state_q    <= prev_valid_q ? StErase : StDraw;
          end
        end
        StErase: begin
          if (handoff_q) begin
            handoff_q <= 1'b0;
            state_q   <= StDraw;
          end else if (last) begin
            handoff_q <= 1'b1;
          end
        end
        StDraw: begin
          if (last) begin
            done_q  <= 1'b1;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          prev_x_q     <= cur_x_q;
          prev_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_wall_renderer.sv
// Directed frames against a pixel-list model of erase-then-draw, plus hand-computed
// plot counts, column/row coverage and done latencies.
module tb_wall_renderer;
  import wall_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  wall_renderer_if bus ();

  wall_renderer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int colour;
    bit plot;
    bit care;
  } pix_t;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];
  bit   m_prev_valid;
  int   m_prev_x;

  int   st_draw, st_erase, st_lat, st_xmin, st_xmax, st_rows;
  bit   st_row[128];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected pixel stream: optional erase of the old strip, one silent gap, then the draw.
  task automatic build_frame(input int wx, input int hy);
    int hole;
    int sx;
    pix_t p;
    hole = (hy > int'(SCREEN_H - HOLE_HEIGHT)) ? int'(SCREEN_H - HOLE_HEIGHT) : hy;
    exp_q.delete();
    if (m_prev_valid) begin
      for (int r = 0; r < int'(SCREEN_H); r++) begin
        for (int c = 0; c < int'(WALL_WIDTH); c++) begin
          sx = m_prev_x + c;
          p = '{x: sx % 256, y: r, colour: int'(BG_COLOUR), plot: (sx < int'(SCREEN_W)), care: 1'b1};
          exp_q.push_back(p);
        end
      end
      p = '{x: 0, y: 0, colour: 0, plot: 1'b0, care: 1'b0};
      exp_q.push_back(p);
    end
    for (int r = 0; r < int'(SCREEN_H); r++) begin
      for (int c = 0; c < int'(WALL_WIDTH); c++) begin
        sx = wx + c;
        p = '{x: sx % 256, y: r, colour: int'(WALL_COLOUR),
              plot: (sx < int'(SCREEN_W)) && !(r >= hole && r < hole + int'(HOLE_HEIGHT)),
              care: 1'b1};
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn    = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_colour", bus.colour, 0);
    resetn       = 1'b1;
    m_prev_valid = 1'b0;
    m_prev_x     = 0;
  endtask

  task automatic run_frame(input int wx, input int hy, input bit hold_start,
                           input int pulse_at, input int abort_at);
    int   idx;
    int   exp_len;
    bit   stop;
    pix_t e;
    build_frame(wx, hy);
    exp_len  = exp_q.size();
    st_draw  = 0;
    st_erase = 0;
    st_lat   = -1;
    st_xmin  = 999;
    st_xmax  = -1;
    st_rows  = 0;
    foreach (st_row[i]) st_row[i] = 1'b0;
    stop = 1'b0;

    bus.start  = 1'b1;
    bus.wall_x = 8'(wx);
    bus.hole_y = 7'(hy);
    @(posedge clk);
    for (int cyc = 0; cyc <= 1100 && !stop; cyc++) begin
      @(negedge clk);
      bus.start = hold_start || (cyc == pulse_at);
      if (cyc == 0) begin
        bus.wall_x = 8'($urandom);
        bus.hole_y = 7'($urandom);
      end
      chk("busy", bus.busy, 1);
      chk("done", bus.done, int'(cyc == exp_len));
      if (cyc == 0) begin
        chk("plot_accept", bus.plot, 0);
      end else begin
        idx = cyc - 1;
        if (idx < exp_len) begin
          e = exp_q[idx];
          chk("plot", bus.plot, int'(e.plot));
          if (e.care) begin
            chk("x", bus.x, e.x);
            chk("y", bus.y, e.y);
            chk("colour", bus.colour, e.colour);
          end
        end else begin
          chk("plot_overrun", bus.plot, 0);
        end
        if (bus.plot === 1'b1 && bus.colour == WALL_COLOUR) begin
          st_draw++;
          if (int'(bus.x) < st_xmin) st_xmin = int'(bus.x);
          if (int'(bus.x) > st_xmax) st_xmax = int'(bus.x);
          if (!st_row[bus.y]) st_rows++;
          st_row[bus.y] = 1'b1;
        end else if (bus.plot === 1'b1) begin
          st_erase++;
        end
      end
      if (bus.done === 1'b1) begin
        st_lat = cyc + 1;
        stop   = 1'b1;
      end else if (cyc == abort_at) begin
        resetn    = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_plot", bus.plot, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_x", bus.x, 0);
        chk("abort_y", bus.y, 0);
        resetn       = 1'b1;
        m_prev_valid = 1'b0;
        m_prev_x     = 0;
        stop         = 1'b1;
      end
    end

    if (abort_at < 0) begin
      if (st_lat < 0) chk("done_timeout", 0, 1);
      m_prev_valid = 1'b1;
      m_prev_x     = wx;
      // FINISH -> IDLE; the idle cycle must show nothing in flight.
      @(posedge clk);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_plot", bus.plot, 0);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    bus.start  = 1'b0;
    bus.wall_x = '0;
    bus.hole_y = '0;
    m_prev_valid = 1'b0;
    m_prev_x     = 0;

    do_reset();

    // First frame after reset: draw only.
    run_frame(100, 30, 1'b0, -1, -1);
    chk("A_draw_plots", st_draw, 280);
    chk("A_erase_plots", st_erase, 0);
    chk("A_latency", st_lat, 481);
    chk("A_xmin", st_xmin, 100);
    chk("A_xmax", st_xmax, 103);
    chk("A_rows", st_rows, 70);
    chk("A_row29", int'(st_row[29]), 1);
    chk("A_row30", int'(st_row[30]), 0);
    chk("A_row79", int'(st_row[79]), 0);
    chk("A_row80", int'(st_row[80]), 1);

    // Erase at 100..103 then draw at 96..99; start held high throughout.
    run_frame(96, 30, 1'b1, -1, -1);
    chk("B_erase_plots", st_erase, 480);
    chk("B_draw_plots", st_draw, 280);
    chk("B_latency", st_lat, 962);
    chk("B_xmin", st_xmin, 96);
    chk("B_xmax", st_xmax, 99);

    // Accepted on the idle cycle right after B; hole_y=100 clamps to 70.
    run_frame(50, 100, 1'b0, -1, -1);
    chk("C_erase_plots", st_erase, 480);
    chk("C_draw_plots", st_draw, 280);
    chk("C_latency", st_lat, 962);
    chk("C_rows", st_rows, 70);
    chk("C_row69", int'(st_row[69]), 1);
    chk("C_row70", int'(st_row[70]), 0);

    do_reset();
    run_frame(158, 30, 1'b0, -1, -1);
    chk("D_draw_plots", st_draw, 140);
    chk("D_xmin", st_xmin, 158);
    chk("D_xmax", st_xmax, 159);
    chk("D_latency", st_lat, 481);

    do_reset();
    run_frame(160, 30, 1'b0, -1, -1);
    chk("E_draw_plots", st_draw, 0);
    chk("E_latency", st_lat, 481);

    // Erase of 160..163 is fully clipped; a start pulse mid-DRAW must be ignored.
    run_frame(20, 10, 1'b0, 531, -1);
    chk("F_erase_plots", st_erase, 0);
    chk("F_draw_plots", st_draw, 280);
    chk("F_latency", st_lat, 962);

    // Reset at DRAW pixel 200 of an erasing frame, then the next frame skips ERASE.
    run_frame(40, 60, 1'b0, -1, 681);
    run_frame(70, 0, 1'b0, -1, -1);
    chk("H_erase_plots", st_erase, 0);
    chk("H_draw_plots", st_draw, 280);
    chk("H_latency", st_lat, 481);
    chk("H_row49", int'(st_row[49]), 0);
    chk("H_row50", int'(st_row[50]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wall_renderer.md
WALL_RENDERER -- requirements
Module: wall_renderer

Interface
REQ-001 SCREEN_W, 160, visible columns; pixels at x >= SCREEN_W are clipped.
REQ-002 SCREEN_H, 120, visible rows.
REQ-003 WALL_WIDTH, 4, wall thickness in pixels.
REQ-004 HOLE_HEIGHT, 50, gap height in pixels.
REQ-005 WALL_COLOUR, 3'b010, colour of drawn wall pixels.
REQ-006 BG_COLOUR, 3'b000, colour used when erasing.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 resetn  in  1  synchronous, active-low reset.
REQ-009 start  in  1  request to render one frame of the wall; sampled only in IDLE.
REQ-010 wall_x  in  8  left edge of the wall from the wall datapath (0..160).
REQ-011 hole_y  in  7  top row of the hole.
REQ-012 x  out  8  pixel column to the VGA adapter.
REQ-013 y  out  7  pixel row to the VGA adapter.
REQ-014 colour  out  3  pixel colour.
REQ-015 plot  out  1  write enable for the current x/y/colour.
REQ-016 busy  out  1  high from the cycle after start is accepted until done.
REQ-017 done  out  1  one-cycle pulse when the frame is complete.

Function
REQ-018 The FSM SHALL have the states IDLE, ERASE, DRAW and FINISH.
REQ-019 In IDLE, start=1 SHALL latch wall_x into cur_x and clamp hole_y to min(hole_y, SCREEN_H-HOLE_HEIGHT) into cur_hole.
- Next state: ERASE if prev_valid=1, else DRAW.
REQ-020 ERASE SHALL scan rows 0..SCREEN_H-1, with columns 0..WALL_WIDTH-1 as the inner loop, at one pixel per cycle.
- Pixel: x = prev_x + col, colour = BG_COLOUR.
- Duration: exactly WALL_WIDTH*SCREEN_H cycles (480 at defaults).
REQ-021 DRAW SHALL scan the same order at x = cur_x + col with colour WALL_COLOUR, for 480 cycles.
- Rows with cur_hole <= y < cur_hole+HOLE_HEIGHT SHALL have plot=0.
REQ-022 The column sum SHALL be computed in 9 bits; any pixel with sum >= SCREEN_W SHALL have plot=0 and x = sum[7:0].
REQ-023 x, y, colour and plot SHALL be registered and valid in the cycle after the scan counter holds that pixel.
REQ-024 FINISH SHALL last one cycle with done=1.
- prev_x <= cur_x, prev_valid <= 1, then the FSM returns to IDLE.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-026 start held high continuously SHALL begin a new frame on the cycle after FINISH.
REQ-027 Inputs wall_x and hole_y SHALL be ignored outside the IDLE accept cycle; mid-frame changes have no effect.
REQ-028 Total latency from the start-accept edge to the done pulse SHALL be 962 cycles with erase and 481 without erase (defaults).

Reset
REQ-029 resetn=0 at a clock edge SHALL force IDLE, even mid-frame.
- Cleared: plot=0, done=0, busy=0, x=0, y=0, colour=0, prev_valid=0, prev_x=0, counters=0.
REQ-030 After reset, the first frame SHALL skip ERASE.

Structure
REQ-031 Package wall_pkg SHALL hold SCREEN_W, SCREEN_H, WALL_WIDTH, HOLE_HEIGHT, the colour constants and the state encoding.
- The wall datapath and the wall height generator share this package.
REQ-032 Sub-module pixel_scan_counter SHALL provide col/row counters with a clear input, an enable input and a last-pixel flag.
- wall_renderer instantiates it once and reuses it for ERASE and DRAW.

Verification
REQ-033 Reset, then start with wall_x=100, hole_y=30:
- No ERASE.
- 480 DRAW cycles, of which 280 have plot=1.
- Writes cover x 100..103 and rows 0..29 and 80..119.
- done fires 481 cycles after the accept edge.
REQ-034 Second frame with wall_x=96, hole_y=30:
- 480 ERASE pixels at x 100..103 with colour 0 come first.
- DRAW follows at x 96..99.
- done fires at cycle 962.
REQ-035 wall_x=158 with prev_valid=0:
- Plotted pixels have x of 158 or 159 only.
- Pixels at 160..161 have plot=0.
REQ-036 wall_x=160: zero plot pulses in DRAW, and done still fires at cycle 481.
REQ-037 hole_y=100 clamps to 70: rows 70..119 are unplotted.
REQ-038 A start pulse mid-DRAW is ignored.
- resetn=0 at DRAW cycle 200 gives plot=0 and busy=0 on the next cycle.
- The next start skips ERASE.
